// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder stage. It accepts two WIDTH-bit operands and a carry-in
//   over a valid/ready handshake. It then pushes the operand bits, LSB first,
//   through a full-adder slice built from two half-adder cells and an OR gate.
//   The sum is rebuilt in a shift register and is offered, together with the
//   carry-out, over an output valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   a_in/b_in/cin carry valid operands
//   in_ready   block can take operands (IDLE only)
//   a_in,b_in  WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  sum_out/cout_out hold a completed result
//   out_ready  downstream takes the result
//   sum_out    low WIDTH bits of a_in + b_in + cin
//   cout_out   carry out of bit WIDTH-1
//   busy       high while shifting or holding a result

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [WIDTH-1:0] sum_out_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             p_bit, g0_bit, g1_bit, s_bit, c_next;
  logic             accept, last_bit, shifting;
  logic [WIDTH-1:0] sum_word;

  // Full-adder slice: HA(a0,b0) -> HA(partial sum, carry) -> OR of carries.
  half_adder u_ha0 (.a(a_sh_reg[0]), .b(b_sh_reg[0]), .s(p_bit), .c(g0_bit));
  half_adder u_ha1 (.a(p_bit),       .b(carry_reg),   .s(s_bit), .c(g1_bit));
  assign c_next = g0_bit | g1_bit;

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign shifting  = (state_reg == SHIFT);
  assign last_bit  = (cnt_reg == CW'(WIDTH - 1));
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign sum_out   = sum_out_reg;
  assign cout_out  = cout_reg;

  // sum_word is the sum register as it looks after this cycle's shift. The
  // partial register only needs WIDTH-1 bits because the final bit goes
  // straight into sum_out on the last edge.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_word = s_bit;
    end else begin : g_wn
      logic [WIDTH-2:0] part_reg;
      assign sum_word = {s_bit, part_reg};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          part_reg <= '0;
        end else if (accept) begin
          part_reg <= '0;
        end else if (shifting) begin
          part_reg <= sum_word[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      sum_out_reg <= '0;
      cout_reg    <= 1'b0;
    end else if (accept) begin
      a_sh_reg  <= a_in;
      b_sh_reg  <= b_in;
      carry_reg <= cin;
      cnt_reg   <= '0;
    end else if (shifting) begin
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      carry_reg <= c_next;
      cnt_reg   <= cnt_reg + CW'(1);
      // Outputs change only when a new result completes.
      if (last_bit) begin
        sum_out_reg <= sum_word;
        cout_reg    <= c_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         busy;

  // WIDTH=1 instance
  logic         v1 = 1'b0;
  logic         r1;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         c1 = 1'b0;
  logic         ov1;
  logic         or1 = 1'b1;
  logic [0:0]   s1;
  logic         co1;
  logic         busy1;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .cout_out(cout_out), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
    .a_in(a1), .b_in(b1), .cin(c1), .out_valid(ov1),
    .out_ready(or1), .sum_out(s1), .cout_out(co1), .busy(busy1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W:0] exp;
    int         acc_cyc;
  } txn_t;
  txn_t q[$];

  bit bp_hold = 1'b0;
  bit rand_bp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: drives out_ready, checks hold/backpressure behaviour and pops
  // the scoreboard whenever a result is handed over.
  logic         prev_ov = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout;
  always @(negedge clk) begin
    out_ready = bp_hold ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_low_in_done", in_ready, 0);
        if (!prev_ov) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum_out);
          end else begin
            chk("latency", cyc - q[0].acc_cyc, W);
          end
        end else begin
          chk("hold_sum", sum_out, hold_sum);
          chk("hold_cout", cout_out, hold_cout);
        end
        hold_sum  = sum_out;
        hold_cout = cout_out;
        if (out_ready && q.size() != 0) begin
          chk("sum", sum_out, q[0].exp[W-1:0]);
          chk("cout", cout_out, q[0].exp[W]);
          $display("[TB] result sum=0x%02h cout=%0d exp=0x%03h", sum_out, cout_out, q[0].exp);
          void'(q.pop_front());
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    q.push_back('{exp: {1'b0, a} + {1'b0, b} + c, acc_cyc: cyc});
    in_valid = 1'b0;
    // Operands after the accept edge must not matter.
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] e1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", cout_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Directed vectors
    send(8'h3C, 8'h5A, 1'b0);
    wait_idle();
    send(8'hFF, 8'h01, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);
    wait_idle();

    // Backpressure: hold the result, ignore a stray in_valid.
    bp_hold = 1'b1;
    send(8'h3C, 8'h5A, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    repeat (2) @(negedge clk);
    a_in = 8'h11; b_in = 8'h00; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    #1 bp_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_released_idle", in_ready, 1);
    chk("bp_consumed", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("stray_ignored_busy", busy, 0);

    // Reset during SHIFT after three bits.
    send(8'h77, 8'h99, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum_out, 0);
    chk("mid_rst_cout", cout_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    send(8'h01, 8'h01, 1'b0);
    wait_idle();

    // Randomised vectors with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    wait_idle();
    rand_bp = 1'b0;

    // WIDTH=1 instance: all eight input combinations.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = 1'(i); b1 = 1'(i >> 1); c1 = 1'(i >> 2); v1 = 1'b1;
      n = 0;
      while (!r1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("w1_in_ready", r1, 1);
      @(posedge clk);
      #1 v1 = 1'b0;
      e1 = 2'(i & 1) + 2'((i >> 1) & 1) + 2'((i >> 2) & 1);
      @(negedge clk);
      chk("w1_not_yet_valid", ov1, 0);
      @(negedge clk);
      chk("w1_valid", ov1, 1);
      chk("w1_result", {co1, s1}, e1);
      $display("[TB] w1 a=%0d b=%0d c=%0d -> sum=%0d cout=%0d", i & 1, (i >> 1) & 1, (i >> 2) & 1, s1, co1);
      @(negedge clk);
      chk("w1_consumed", ov1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
